// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: states, opcodes,
// datapath-select encodings and the bundled control-word type.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADDR = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXEC    = 4'd6,
      RCOMP   = 4'd7,
      BRANCH  = 4'd8,
      JUMP    = 4'd9,
      ADDIEX  = 4'd10,
      ADDIWB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BROFF = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       alu_src_a;
      logic       reg_write;
      logic       reg_dst;
      logic [1:0] alu_op;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

   // States whose exit back to FETCH completes (retires) an instruction.
   function automatic logic is_retire_state(state_t s);
      return (s == MEMWB) || (s == MEMWR) || (s == RCOMP) ||
             (s == BRANCH) || (s == JUMP) || (s == ADDIWB);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: instruction/memory status in, control strobes out.
interface multicycle_control_if #(
   parameter int OPW  = 6,
   parameter int CNTW = 32
);
   logic [OPW-1:0]  opcode;
   logic            mem_ready;
   logic            PCWrite;
   logic            PCWriteCond;
   logic            IorD;
   logic            MemRead;
   logic            MemWrite;
   logic            MemtoReg;
   logic            IRWrite;
   logic            ALUSrcA;
   logic            RegWrite;
   logic            RegDst;
   logic [1:0]      ALUOp;
   logic [1:0]      ALUSrcB;
   logic [1:0]      PCSource;
   logic            illegal_op;
   logic [CNTW-1:0] instr_count;

   modport master (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, illegal_op,
             instr_count
   );

   modport slave (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, illegal_op,
             instr_count
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM (lw/sw/R-type/beq/j/addi) with a retired-instruction
// counter; outputs are forced low while reset is asserted.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int OPW  = 6,
   parameter int CNTW = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   multicycle_control_if.slave bus
);

   state_t          state_q, state_d;
   logic            is_sw_q, is_sw_d;
   logic [CNTW-1:0] count_q, count_d;
   ctrl_t           ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         is_sw_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         is_sw_q <= is_sw_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = FETCH;
      is_sw_d = is_sw_q;
      count_d = count_q;
      ctrl    = '0;

      case (state_q)
         FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            if (bus.mem_ready) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
               state_d       = DECODE;
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            ctrl.alu_src_b = SRCB_BROFF;
            // The opcode is only ever looked at here; lw vs sw is remembered for MEMADDR.
            case (bus.opcode)
               OPW'(OP_LW):   begin state_d = MEMADDR; is_sw_d = 1'b0; end
               OPW'(OP_SW):   begin state_d = MEMADDR; is_sw_d = 1'b1; end
               OPW'(OP_R):    state_d = EXEC;
               OPW'(OP_BEQ):  state_d = BRANCH;
               OPW'(OP_J):    state_d = JUMP;
               OPW'(OP_ADDI): state_d = ADDIEX;
               default: begin
                  ctrl.illegal_op = 1'b1;
                  state_d         = FETCH;
               end
            endcase
         end
         MEMADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            state_d        = is_sw_q ? MEMWR : MEMRD;
         end
         MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
            state_d       = bus.mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            state_d         = FETCH;
         end
         MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
            state_d        = bus.mem_ready ? FETCH : MEMWR;
         end
         EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
            state_d        = RCOMP;
         end
         RCOMP: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            state_d        = FETCH;
         end
         BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            state_d            = FETCH;
         end
         JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
            state_d        = FETCH;
         end
         ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
            state_d        = ADDIWB;
         end
         ADDIWB: begin
            ctrl.reg_write = 1'b1;
            state_d        = FETCH;
         end
         default: state_d = FETCH;
      endcase

      if ((state_d == FETCH) && is_retire_state(state_q))
         count_d = count_q + CNTW'(1);

      // Reset must silence FETCH's Moore outputs too, not just the state register.
      if (!rst_n)
         ctrl = '0;
   end

   assign bus.PCWrite     = ctrl.pc_write;
   assign bus.PCWriteCond = ctrl.pc_write_cond;
   assign bus.IorD        = ctrl.iord;
   assign bus.MemRead     = ctrl.mem_read;
   assign bus.MemWrite    = ctrl.mem_write;
   assign bus.MemtoReg    = ctrl.mem_to_reg;
   assign bus.IRWrite     = ctrl.ir_write;
   assign bus.ALUSrcA     = ctrl.alu_src_a;
   assign bus.RegWrite    = ctrl.reg_write;
   assign bus.RegDst      = ctrl.reg_dst;
   assign bus.ALUOp       = ctrl.alu_op;
   assign bus.ALUSrcB     = ctrl.alu_src_b;
   assign bus.PCSource    = ctrl.pc_source;
   assign bus.illegal_op  = ctrl.illegal_op;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control words and retire counts,
// with a narrow-counter instance tracking the same stimulus for the wrap case.
module tb_multicycle_control;

   localparam logic [5:0] T_R    = 6'b000000;
   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_ADDI = 6'b001000;
   localparam logic [5:0] T_BAD  = 6'b111111;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,ALUOp,ALUSrcB,PCSource,illegal_op}
   localparam logic [16:0] E_ZERO      = 17'b0000000000_00_00_00_0;
   localparam logic [16:0] E_FETCH_RDY = 17'b1001001000_00_01_00_0;
   localparam logic [16:0] E_FETCH_W   = 17'b0001000000_00_01_00_0;
   localparam logic [16:0] E_DECODE    = 17'b0000000000_00_11_00_0;
   localparam logic [16:0] E_DEC_ILL   = 17'b0000000000_00_11_00_1;
   localparam logic [16:0] E_MEMADDR   = 17'b0000000100_00_10_00_0;
   localparam logic [16:0] E_MEMRD     = 17'b0011000000_00_00_00_0;
   localparam logic [16:0] E_MEMWB     = 17'b0000010010_00_00_00_0;
   localparam logic [16:0] E_MEMWR     = 17'b0010100000_00_00_00_0;
   localparam logic [16:0] E_EXEC      = 17'b0000000100_10_00_00_0;
   localparam logic [16:0] E_RCOMP     = 17'b0000000011_00_00_00_0;
   localparam logic [16:0] E_BRANCH    = 17'b0100000100_01_00_01_0;
   localparam logic [16:0] E_JUMP      = 17'b1000000000_00_00_10_0;
   localparam logic [16:0] E_ADDIEX    = 17'b0000000100_00_10_00_0;
   localparam logic [16:0] E_ADDIWB    = 17'b0000000010_00_00_00_0;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   multicycle_control_if #(.OPW(6), .CNTW(32)) cif ();
   multicycle_control_if #(.OPW(6), .CNTW(3))  wif ();

   assign wif.opcode    = cif.opcode;
   assign wif.mem_ready = cif.mem_ready;

   multicycle_control #(.OPW(6), .CNTW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (cif)
   );

   multicycle_control #(.OPW(6), .CNTW(3)) dut_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (wif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [16:0] outs();
      return {cif.PCWrite, cif.PCWriteCond, cif.IorD, cif.MemRead, cif.MemWrite,
              cif.MemtoReg, cif.IRWrite, cif.ALUSrcA, cif.RegWrite, cif.RegDst,
              cif.ALUOp, cif.ALUSrcB, cif.PCSource, cif.illegal_op};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      cif.mem_ready = 1'b1;
      cif.opcode = T_LW;
      @(negedge clk); @(negedge clk); #1;
      total++;
      if (outs() !== E_ZERO) $display("FAIL reset_outs: got %b expected %b", outs(), E_ZERO); else passed++;
      total++;
      if (cif.instr_count !== 32'd0) $display("FAIL reset_count: got %0d expected 0", cif.instr_count); else passed++;
      @(negedge clk); cif.mem_ready = 1'b0; rst_n = 1'b1; #1;
      total++;
      if (outs() !== E_FETCH_W) $display("FAIL release_fetch: got %b expected %b", outs(), E_FETCH_W); else passed++;
      @(negedge clk); #1;
      total++;
      if (outs() !== E_FETCH_W) $display("FAIL fetch_hold: got %b expected %b", outs(), E_FETCH_W); else passed++;
   endtask

   task automatic test_lw();
      logic [5:0]  op [5] = '{T_LW, T_LW, T_BAD, 6'h15, 6'h2A};
      logic [16:0] ev [5] = '{E_FETCH_RDY, E_DECODE, E_MEMADDR, E_MEMRD, E_MEMWB};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); cif.opcode = op[i]; cif.mem_ready = 1'b1; #1;
         total++;
         if (outs() !== ev[i]) $display("FAIL lw_cycle%0d: got %b expected %b", i, outs(), ev[i]); else passed++;
      end
      @(posedge clk); #1;
      total++;
      if (cif.instr_count !== 32'd1) $display("FAIL lw_count: got %0d expected 1", cif.instr_count); else passed++;
      total++;
      if (outs() !== E_FETCH_RDY) $display("FAIL lw_refetch: got %b expected %b", outs(), E_FETCH_RDY); else passed++;
   endtask

   task automatic test_sw_wait();
      logic [5:0]  op  [7] = '{T_SW, T_SW, T_R, T_R, T_J, T_BEQ, T_R};
      logic        rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [16:0] ev  [7] = '{E_FETCH_RDY, E_DECODE, E_MEMADDR, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR};
      int mw_cycles = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); cif.opcode = op[i]; cif.mem_ready = rdy[i]; #1;
         if (cif.MemWrite === 1'b1) mw_cycles++;
         total++;
         if (outs() !== ev[i]) $display("FAIL sw_cycle%0d: got %b expected %b", i, outs(), ev[i]); else passed++;
      end
      total++;
      if (mw_cycles !== 4) $display("FAIL sw_memwrite_cycles: got %0d expected 4", mw_cycles); else passed++;
      @(posedge clk); #1;
      total++;
      if (cif.instr_count !== 32'd2) $display("FAIL sw_count: got %0d expected 2", cif.instr_count); else passed++;
      total++;
      if (outs() !== E_FETCH_RDY) $display("FAIL sw_refetch: got %b expected %b", outs(), E_FETCH_RDY); else passed++;
   endtask

   task automatic test_rtype();
      logic [5:0]  op  [6] = '{T_BEQ, T_J, T_R, T_R, T_LW, T_SW};
      logic        rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [16:0] ev  [6] = '{E_FETCH_W, E_FETCH_W, E_FETCH_RDY, E_DECODE, E_EXEC, E_RCOMP};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); cif.opcode = op[i]; cif.mem_ready = rdy[i]; #1;
         total++;
         if (outs() !== ev[i]) $display("FAIL rtype_cycle%0d: got %b expected %b", i, outs(), ev[i]); else passed++;
      end
      @(posedge clk); #1;
      total++;
      if (cif.instr_count !== 32'd3) $display("FAIL rtype_count: got %0d expected 3", cif.instr_count); else passed++;
   endtask

   task automatic test_branch_jump();
      logic [5:0]  op [6] = '{T_BEQ, T_BEQ, T_SW, T_J, T_J, T_LW};
      logic [16:0] ev [6] = '{E_FETCH_RDY, E_DECODE, E_BRANCH, E_FETCH_RDY, E_DECODE, E_JUMP};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); cif.opcode = op[i]; cif.mem_ready = 1'b1; #1;
         total++;
         if (outs() !== ev[i]) $display("FAIL bj_cycle%0d: got %b expected %b", i, outs(), ev[i]); else passed++;
      end
      @(posedge clk); #1;
      total++;
      if (cif.instr_count !== 32'd5) $display("FAIL bj_count: got %0d expected 5", cif.instr_count); else passed++;
   endtask

   task automatic test_illegal();
      @(negedge clk); cif.opcode = T_BAD; cif.mem_ready = 1'b1; #1;
      total++;
      if (outs() !== E_FETCH_RDY) $display("FAIL ill_fetch: got %b expected %b", outs(), E_FETCH_RDY); else passed++;
      @(negedge clk); #1;
      total++;
      if (outs() !== E_DEC_ILL) $display("FAIL ill_decode: got %b expected %b", outs(), E_DEC_ILL); else passed++;
      @(posedge clk); #1;
      total++;
      if (outs() !== E_FETCH_RDY) $display("FAIL ill_back_to_fetch: got %b expected %b", outs(), E_FETCH_RDY); else passed++;
      total++;
      if (cif.instr_count !== 32'd5) $display("FAIL ill_count: got %0d expected 5", cif.instr_count); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [5:0]  op [8] = '{T_ADDI, T_ADDI, T_J, T_BEQ, T_ADDI, T_ADDI, T_R, T_SW};
      logic [16:0] ev [8] = '{E_FETCH_RDY, E_DECODE, E_ADDIEX, E_ADDIWB,
                              E_FETCH_RDY, E_DECODE, E_ADDIEX, E_ADDIWB};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); cif.opcode = op[i]; cif.mem_ready = 1'b1; #1;
         total++;
         if (outs() !== ev[i]) $display("FAIL addi_cycle%0d: got %b expected %b", i, outs(), ev[i]); else passed++;
      end
      @(posedge clk); #1;
      total++;
      if (cif.instr_count !== 32'd7) $display("FAIL addi_count: got %0d expected 7", cif.instr_count); else passed++;
   endtask

   task automatic test_async_reset();
      logic [5:0]  op  [4] = '{T_LW, T_LW, T_R, T_R};
      logic        rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [16:0] ev  [4] = '{E_FETCH_RDY, E_DECODE, E_MEMADDR, E_MEMRD};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); cif.opcode = op[i]; cif.mem_ready = rdy[i]; #1;
         total++;
         if (outs() !== ev[i]) $display("FAIL ar_cycle%0d: got %b expected %b", i, outs(), ev[i]); else passed++;
      end
      total++;
      if (cif.instr_count !== 32'd7) $display("FAIL ar_precount: got %0d expected 7", cif.instr_count); else passed++;
      #2; cif.mem_ready = 1'b1; rst_n = 1'b0; #1;
      total++;
      if (outs() !== E_ZERO) $display("FAIL ar_outs_async: got %b expected %b", outs(), E_ZERO); else passed++;
      total++;
      if (cif.instr_count !== 32'd0) $display("FAIL ar_count_async: got %0d expected 0", cif.instr_count); else passed++;
      total++;
      if (wif.instr_count !== 3'd0) $display("FAIL ar_wrap_count: got %0d expected 0", wif.instr_count); else passed++;
      @(negedge clk); #1;
      total++;
      if (outs() !== E_ZERO) $display("FAIL ar_outs_held: got %b expected %b", outs(), E_ZERO); else passed++;
      @(negedge clk); cif.mem_ready = 1'b0; rst_n = 1'b1; #1;
      total++;
      if (outs() !== E_FETCH_W) $display("FAIL ar_release_fetch: got %b expected %b", outs(), E_FETCH_W); else passed++;
   endtask

   task automatic test_wrap();
      logic [16:0] ev_j [3] = '{E_FETCH_RDY, E_DECODE, E_JUMP};
      logic [16:0] ev_r [4] = '{E_FETCH_RDY, E_DECODE, E_EXEC, E_RCOMP};
      for (int k = 0; k < 7; k++) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clk); cif.opcode = T_J; cif.mem_ready = 1'b1; #1;
            total++;
            if (outs() !== ev_j[i]) $display("FAIL wrap_j%0d_cycle%0d: got %b expected %b", k, i, outs(), ev_j[i]); else passed++;
         end
      end
      @(posedge clk); #1;
      total++;
      if (wif.instr_count !== 3'd7) $display("FAIL wrap_preload: got %0d expected 7", wif.instr_count); else passed++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); cif.opcode = T_R; cif.mem_ready = 1'b1; #1;
         total++;
         if (outs() !== ev_r[i]) $display("FAIL wrap_r_cycle%0d: got %b expected %b", i, outs(), ev_r[i]); else passed++;
      end
      @(posedge clk); #1;
      total++;
      if (wif.instr_count !== 3'd0) $display("FAIL wrap_to_zero: got %0d expected 0", wif.instr_count); else passed++;
      total++;
      if (cif.instr_count !== 32'd8) $display("FAIL wide_no_wrap: got %0d expected 8", cif.instr_count); else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_lw();
      test_sw_wait();
      test_rtype();
      test_branch_jump();
      test_illegal();
      test_back_to_back();
      test_async_reset();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPW, default 6, sets the opcode field width.
REQ-002 Parameter CNTW, default 32, sets the retired-instruction counter width.
REQ-003 clk  input  1  clock; all state updates occur on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 opcode  input  OPW  instruction[31:26] from the instruction register.
REQ-006 mem_ready  input  1  memory has completed the current read or write this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  standard multicycle datapath controls.
REQ-008 ALUOp, ALUSrcB, PCSource  output  2 each  ALU-op class, B-operand select, and next-PC select.
REQ-009 illegal_op  output  1  one-cycle pulse on an undecodable opcode.
REQ-010 instr_count  output  CNTW  count of retired instructions.

Function
REQ-011 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC, RCOMP, BRANCH, JUMP, ADDIEX, ADDIWB; every output not listed for a state SHALL be 0.
REQ-012 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, and drive IRWrite=1 and PCWrite=1 only when mem_ready=1; on mem_ready=1 go to DECODE, otherwise hold.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, then branch on opcode: 100011/101011 to MEMADDR, 000000 to EXEC, 000100 to BRANCH, 000010 to JUMP, 001000 to ADDIEX, and any other value to FETCH with illegal_op=1 for that cycle.
REQ-014 MEMADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD for lw or MEMWR for sw.
REQ-015 MEMRD SHALL drive MemRead=1, IorD=1, hold until mem_ready=1, then go to MEMWB.
REQ-016 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1, then go to FETCH.
REQ-017 MEMWR SHALL drive MemWrite=1, IorD=1, hold until mem_ready=1, then go to FETCH.
REQ-018 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RCOMP; RCOMP SHALL drive RegDst=1, MemtoReg=0, RegWrite=1, then go to FETCH.
REQ-019 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-020 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-021 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB; ADDIWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1, then go to FETCH.
REQ-022 The FSM SHALL sample opcode only in DECODE; changes to opcode in any other state SHALL have no effect.
REQ-023 Instruction latency without wait states SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
REQ-024 instr_count SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWR, RCOMP, BRANCH, JUMP, or ADDIWB, wrap modulo 2^CNTW, and not increment on the illegal-opcode path.
REQ-025 Unreachable state encodings SHALL transition to FETCH on the next clock edge.

Reset
REQ-026 While rst_n=0, the block SHALL force state=FETCH and instr_count=0, and SHALL force every output to 0, including the FETCH Moore outputs.
REQ-027 Asserting rst_n mid-instruction, including during a MEMRD or MEMWR wait, SHALL abandon that instruction without incrementing instr_count.
REQ-028 In the first cycle after rst_n rises, the block SHALL present FETCH outputs.

Structure
REQ-029 The state enumeration, the opcode constants (R, LW, SW, BEQ, J, ADDI), and the ALUOp/ALUSrcB/PCSource encodings SHALL reside in a shared package, mips_ctrl_pkg.
REQ-030 The block SHALL be a single module with no sub-modules, built as one registered state process plus combinational next-state and output logic.

Verification
REQ-031 Reset, release rst_n, mem_ready=1, opcode=100011 -> states FETCH, DECODE, MEMADDR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5; instr_count=1.
REQ-032 sw with mem_ready low for 3 cycles in MEMWR -> MemWrite held high for 4 cycles; FETCH re-entered after mem_ready; instr_count increments once.
REQ-033 beq then j -> PCWriteCond=1 with PCSource=01 for exactly 1 cycle, then PCWrite=1 with PCSource=10 for 1 cycle; instr_count=2.
REQ-034 opcode=111111 in DECODE -> illegal_op pulses for 1 cycle, next state is FETCH, instr_count unchanged.
REQ-035 Drop rst_n in MEMRD with instr_count=7 -> all outputs 0 immediately (asynchronously), instr_count=0, FETCH presented after release.
REQ-036 Preload instr_count to 2^CNTW-1, then retire a R-type instruction -> instr_count=0.
